// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the streaming I2C master.
//            Holds the transaction state encoding, the SSD1306-style control
//            byte values and the number of SCL bits per byte (8 data + ACK).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    CTRL  = 3'd3,
    DATA  = 3'd4,
    ACK   = 3'd5,
    STOP  = 3'd6
  } state_t;

  localparam logic [7:0] CTRL_CMD      = 8'h00;
  localparam logic [7:0] CTRL_DATA     = 8'h40;
  localparam int         BITS_PER_BYTE = 9;

  // Control byte that precedes the payload: command stream or GDDRAM data.
  function automatic logic [7:0] ctrl_byte(input logic dc_bit);
    return dc_bit ? CTRL_DATA : CTRL_CMD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_quarter_tick
// Purpose  : Quarter-period timebase for the I2C master. Divides the system
//            clock by CLK_DIV and steps a 2-bit quarter index on each tick.
// Ports    : clock   - system clock
//            reset   - synchronous, active-high
//            enable  - count while high; held cleared while low
//            freeze  - hold divider and quarter index (SCL stretch)
//            restart - clear divider and quarter index
//            tick    - one-cycle pulse on the last clock of a quarter
//            quarter - index of the quarter currently in progress (0..3)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_quarter_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       freeze,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] quarter
);

  // One bit minimum so CLK_DIV=1 still yields a legal (constant-zero) counter.
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Tick marks the final clock of the current quarter, so "end of Qn" is
  // simply tick && quarter == n.
  assign tick = enable && !freeze && !restart && (div_cnt == TERM);

  always_ff @(posedge clock) begin
    if (reset || restart || !enable) begin
      div_cnt <= '0;
      quarter <= 2'd0;
    end else if (!freeze) begin
      if (div_cnt == TERM) begin
        div_cnt <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_master_stream.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_stream
// Purpose  : Write-only I2C master for the OLED path. Sends START, address+W,
//            an optional control byte, a valid/ready stream of payload bytes
//            and STOP. Aborts to STOP on a NACK. SCL is held low while the
//            payload stream is empty.
// Ports    : clock, reset            - system clock, sync active-high reset
//            start                   - one-cycle request, sampled in IDLE
//            addr_sel, addr_in       - address source select / alternate addr
//            dc                      - 0 = command, 1 = data control byte
//            byte_in, byte_last,
//            byte_valid, byte_ready  - payload stream (ready = consumed)
//            busy, done, nack_err    - transaction status
//            scl_oe, sda_oe          - open-drain pull-low enables
//            sda_in                  - synchronised SDA level
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_stream
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 25,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter bit         CTRL_EN    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       addr_sel,
  input  logic [6:0] addr_in,
  input  logic       dc,
  input  logic [7:0] byte_in,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 2);

  state_t     state;
  state_t     state_next;
  state_t     ack_of;      // which byte the current ACK bit belongs to
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [6:0] addr_lat;
  logic       dc_lat;
  logic       have_byte;
  logic       last_byte;
  logic       abort;
  logic       nack_bit;
  logic       scl_d;
  logic       sda_d;

  logic       tick;
  logic [1:0] quarter;
  logic       accept;
  logic       bit_end;
  logic       load;
  logic       freeze;

  assign accept  = (state == IDLE) && start;
  assign bit_end = tick && (quarter == 2'd3);
  // Payload is pulled only at Q0 of the first bit of a DATA byte.
  assign load    = (state == DATA) && !have_byte && byte_valid;
  // Empty stream at byte start: stop the timebase so SCL stays low.
  assign freeze  = (state == DATA) && !have_byte && !byte_valid;

  assign byte_ready = load;
  assign busy       = (state != IDLE);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .enable  (state != IDLE),
    .freeze  (freeze),
    .restart (accept),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    scl_d      = 1'b0;
    sda_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = START;
      end
      START: begin
        // SDA falls in Q2 with SCL still high, then SCL falls in Q3.
        scl_d = (quarter == 2'd3);
        sda_d = quarter[1];
        if (bit_end) state_next = ADDR;
      end
      ADDR, CTRL: begin
        scl_d = !quarter[1];
        sda_d = !shreg[7];
        if (bit_end && (bit_cnt == LAST_BIT)) state_next = ACK;
      end
      DATA: begin
        scl_d = !quarter[1];
        // Before the byte is loaded, present byte_in's MSB on the load cycle
        // or hold SDA where it is while stalled.
        if (have_byte) begin
          sda_d = !shreg[7];
        end else if (byte_valid) begin
          sda_d = !byte_in[7];
        end else begin
          sda_d = sda_oe;
        end
        if (bit_end && (bit_cnt == LAST_BIT)) state_next = ACK;
      end
      ACK: begin
        scl_d = !quarter[1];
        sda_d = 1'b0;
        if (bit_end) begin
          if (nack_bit) begin
            state_next = STOP;
          end else if ((ack_of == DATA) && last_byte) begin
            state_next = STOP;
          end else if ((ack_of == ADDR) && CTRL_EN) begin
            state_next = CTRL;
          end else begin
            state_next = DATA;
          end
        end
      end
      STOP: begin
        // SCL rises in Q2, SDA rises in Q3.
        scl_d = !quarter[1];
        sda_d = (quarter != 2'd3);
        if (bit_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered line drivers (glitch-free pad enables).
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      addr_lat  <= 7'h00;
      dc_lat    <= 1'b0;
      have_byte <= 1'b0;
      last_byte <= 1'b0;
      abort     <= 1'b0;
      nack_bit  <= 1'b0;
      ack_of    <= IDLE;
    end else begin
      scl_oe   <= scl_d;
      sda_oe   <= sda_d;
      done     <= (state == STOP) && bit_end;
      nack_err <= (state == STOP) && bit_end && abort;

      if (accept) begin
        addr_lat <= addr_sel ? addr_in : SLAVE_ADDR;
        dc_lat   <= dc;
        abort    <= 1'b0;
      end

      case (state)
        START: begin
          if (bit_end) begin
            shreg   <= {addr_lat, 1'b0};
            bit_cnt <= 3'd0;
          end
        end
        ADDR, CTRL, DATA: begin
          if (load) begin
            shreg     <= byte_in;
            last_byte <= byte_last;
            have_byte <= 1'b1;
          end
          if (bit_end) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) ack_of <= state;
          end
        end
        ACK: begin
          if (tick && (quarter == 2'd2)) nack_bit <= sda_in;
          if (bit_end) begin
            if (nack_bit) abort <= 1'b1;
            bit_cnt   <= 3'd0;
            have_byte <= 1'b0;
            // Only consumed if the next byte is the control byte.
            shreg     <= ctrl_byte(dc_lat);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_stream
// Purpose  : Directed self-checking bench for i2c_master_stream with an
//            open-drain bus model and an ACKing slave that can NACK a chosen
//            byte.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       addr_sel;
  logic [6:0] addr_in;
  logic       dc;
  logic [7:0] byte_in;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       slave_pull = 1'b0;
  logic       scl_line;
  logic       sda_line;

  assign scl_line = !scl_oe;
  assign sda_line = !(sda_oe || slave_pull);

  always #5 clk = ~clk;

  i2c_master_stream #(
    .CLK_DIV    (2),
    .SLAVE_ADDR (7'h3C),
    .CTRL_EN    (1'b1)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .addr_sel   (addr_sel),
    .addr_in    (addr_in),
    .dc         (dc),
    .byte_in    (byte_in),
    .byte_last  (byte_last),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .nack_err   (nack_err),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_in     (sda_line)
  );

  int checks = 0;
  int errors = 0;

  // Bus / status monitor state (written only by the monitor processes).
  int         cyc = 0;
  logic [7:0] bytes_q[$];
  int         ready_cnt = 0;
  int         done_cnt = 0;
  int         nack_cnt = 0;
  int         stray_nack = 0;
  int         done_cyc = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         hi_bad = 0;
  int         nack_idx = -1;   // byte index the slave refuses; written by stimulus

  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bitcnt = 0;
  int         hi_len = 0;
  logic [7:0] sh = 8'h00;
  bit         rise_valid = 1'b0;

  // Snapshots taken at the start of each transaction.
  int start_cyc, ready_base, done_base, nack_base, bytes_base;
  int start_base, stop_base, hibad_base, stray_base;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #1;
    if (byte_ready) ready_cnt++;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (nack_err) nack_cnt++;
    end else if (nack_err) begin
      stray_nack++;
    end

    if (!busy) begin
      bitcnt     = 0;
      slave_pull = 1'b0;
      rise_valid = 1'b0;
    end
    if (scl_line && prev_scl && prev_sda && !sda_line) begin
      start_cnt++;
      bitcnt = 0;
    end
    if (scl_line && prev_scl && !prev_sda && sda_line) begin
      stop_cnt++;
      rise_valid = 1'b0;
    end
    if (scl_line && !prev_scl) begin
      hi_len     = 1;
      rise_valid = busy;
      if (bitcnt < 8) sh = {sh[6:0], sda_line};
      bitcnt++;
      if (bitcnt == 9) bytes_q.push_back(sh);
    end else if (scl_line) begin
      hi_len++;
    end
    if (!scl_line && prev_scl) begin
      if (rise_valid && (hi_len != 4)) hi_bad++;
      rise_valid = 1'b0;
      if (bitcnt == 8) begin
        slave_pull = (bytes_q.size() != nack_idx);
      end else if (bitcnt >= 9) begin
        slave_pull = 1'b0;
        bitcnt     = 0;
      end
    end
    prev_scl = scl_line;
    prev_sda = !(sda_oe || slave_pull);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the DUT running with start accepted.
  task automatic begin_txn(input logic sel, input logic [6:0] ain, input logic d);
    ready_base = ready_cnt;
    done_base  = done_cnt;
    nack_base  = nack_cnt;
    bytes_base = bytes_q.size();
    start_base = start_cnt;
    stop_base  = stop_cnt;
    hibad_base = hi_bad;
    stray_base = stray_nack;
    addr_sel   = sel;
    addr_in    = ain;
    dc         = d;
    start      = 1'b1;
    start_cyc  = cyc + 1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit got;
    got        = 1'b0;
    byte_in    = b;
    byte_last  = l;
    byte_valid = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      #1;
      if (byte_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("byte_ready_seen", {31'b0, got}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    for (int i = 0; i < 3000 && (done_cnt == done_base); i++) @(negedge clk);
    chk({tag, "_latency"}, done_cyc - start_cyc, exp_lat);
    repeat (12) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt - done_base, 32'd1);
    chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, "_start_cond"}, start_cnt - start_base, 32'd1);
    chk({tag, "_stop_cond"}, stop_cnt - stop_base, 32'd1);
    chk({tag, "_scl_high_len"}, hi_bad - hibad_base, 32'd0);
    chk({tag, "_stray_nack"}, stray_nack - stray_base, 32'd0);
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] obs;
    obs = (bytes_base + idx < bytes_q.size()) ? bytes_q[bytes_base + idx] : 8'hxx;
    chk(tag, {24'b0, obs}, {24'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_bad;
    reset      = 1'b1;
    start      = 1'b0;
    addr_sel   = 1'b0;
    addr_in    = 7'h00;
    dc         = 1'b0;
    byte_in    = 8'h00;
    byte_last  = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", {31'b0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_nack_err", {31'b0, nack_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of the address byte.
    begin_txn(1'b0, 7'h00, 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_scl_oe", {31'b0, scl_oe}, 32'd0);
    chk("midrst_sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrst_no_done", done_cnt - done_base, 32'd0);

    // Command burst, with an ignored start pulse mid-transaction.
    begin_txn(1'b0, 7'h00, 1'b0);
    send_byte(8'hAE, 1'b0);
    start    = 1'b1;
    addr_sel = 1'b1;
    addr_in  = 7'h11;
    dc       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hAF, 1'b1);
    wait_done("cmd", 8 + 4 * 72 + 8);
    chk("cmd_nbytes", bytes_q.size() - bytes_base, 32'd4);
    chk_byte("cmd_addr", 0, 8'h78);
    chk_byte("cmd_ctrl", 1, 8'h00);
    chk_byte("cmd_b0", 2, 8'hAE);
    chk_byte("cmd_b1", 3, 8'hAF);
    chk("cmd_ready_cnt", ready_cnt - ready_base, 32'd2);
    chk("cmd_nack", nack_cnt - nack_base, 32'd0);

    // Data mode, alternate address, single byte.
    begin_txn(1'b1, 7'h3D, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_done("dat", 8 + 3 * 72 + 8);
    chk("dat_nbytes", bytes_q.size() - bytes_base, 32'd3);
    chk_byte("dat_addr", 0, 8'h7A);
    chk_byte("dat_ctrl", 1, 8'h40);
    chk_byte("dat_b0", 2, 8'h55);
    chk("dat_ready_cnt", ready_cnt - ready_base, 32'd1);
    chk("dat_nack", nack_cnt - nack_base, 32'd0);

    // Address NACK with payload offered the whole time.
    nack_idx = bytes_q.size();
    byte_in    = 8'hC3;
    byte_last  = 1'b1;
    byte_valid = 1'b1;
    begin_txn(1'b0, 7'h00, 1'b0);
    wait_done("nack", 8 + 72 + 8);
    byte_valid = 1'b0;
    nack_idx   = -1;
    chk("nack_nbytes", bytes_q.size() - bytes_base, 32'd1);
    chk_byte("nack_addr", 0, 8'h78);
    chk("nack_pulse", nack_cnt - nack_base, 32'd1);
    chk("nack_ready_cnt", ready_cnt - ready_base, 32'd0);

    // Stream stall before the second payload byte.
    begin_txn(1'b0, 7'h00, 1'b0);
    send_byte(8'hAE, 1'b0);
    repeat (74) @(negedge clk);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if ((scl_oe !== 1'b1) || (sda_oe !== 1'b0)) stall_bad++;
      @(negedge clk);
    end
    chk("stall_lines_held", stall_bad, 32'd0);
    send_byte(8'hA5, 1'b1);
    wait_done("stall", 8 + 4 * 72 + 8 + 53);
    chk("stall_nbytes", bytes_q.size() - bytes_base, 32'd4);
    chk_byte("stall_addr", 0, 8'h78);
    chk_byte("stall_ctrl", 1, 8'h00);
    chk_byte("stall_b0", 2, 8'hAE);
    chk_byte("stall_b1", 3, 8'hA5);
    chk("stall_ready_cnt", ready_cnt - ready_base, 32'd2);
    chk("stall_nack", nack_cnt - nack_base, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_stream.md
Name: i2c_master_stream

Overview:
- Parametrised I2C master for the OLED controller path.
- A transaction is: START, 7-bit address + W, optional SSD1306-style control byte, then N streamed payload bytes, then STOP.
- The display sequencer feeds payload bytes over a valid/ready stream.
- Generalises the earlier single-command block with:
  - a programmable bit rate;
  - sampled slave ACK with NACK abort;
  - command/data mode selection;
  - stall-free multi-byte bursts with back-pressure.

Parameters:
- CLK_DIV, 25: system clocks per quarter SCL period; must be >=1; SCL period = 4*CLK_DIV clocks.
- SLAVE_ADDR, 7'h3C: default 7-bit slave address, used when addr_sel=0.
- CTRL_EN, 1: 1 = send a control byte after the address; 0 = payload follows the address directly.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- addr_sel  in  1  0 = use SLAVE_ADDR, 1 = use addr_in
- addr_in  in  7  alternate slave address; latched on start
- dc  in  1  0 = command control byte 8'h00, 1 = data control byte 8'h40; latched on start
- byte_in  in  8  payload byte
- byte_last  in  1  marks final payload byte; qualified by byte_valid
- byte_valid  in  1  payload byte available
- byte_ready  out  1  one-cycle pulse: byte_in/byte_last consumed this cycle
- busy  out  1  high from accepted start until STOP completes
- done  out  1  one-cycle pulse at the end of STOP
- nack_err  out  1  one-cycle pulse, coincident with done, when a transaction was aborted by NACK
- scl_oe  out  1  1 = pull SCL low (open drain)
- sda_oe  out  1  1 = pull SDA low (open drain)
- sda_in  in  1  SDA line level; already synchronised by the pad block

Behaviour:
Reset and idle:
- Reset values: scl_oe=0, sda_oe=0, busy=0, byte_ready=0, done=0, nack_err=0.
- All counters clear; state = IDLE.
- Reset mid-transaction releases both lines on the next edge. No STOP is generated.

Timing:
- A quarter tick fires every CLK_DIV clocks while not IDLE. The counter restarts on the accepted start.
- Each bit is 4 quarters:
  - Q0: SCL low; SDA changes here.
  - Q1: SCL low.
  - Q2: SCL high.
  - Q3: SCL high.
- SDA is sampled at the end of Q2.
- Each byte is 9 bits (8 data bits MSB-first, then the ACK bit, during which the master releases SDA): 36*CLK_DIV clocks.

States and transitions:
- IDLE: start=1 latches the address and dc, sets busy=1, goes to START.
- START:
  - Q0–Q1: both lines released.
  - Q2: SDA low while SCL is high.
  - Q3: SCL low.
  - Then go to ADDR.
- ADDR: shift {addr,1'b0}, then ACK.
- CTRL (only if CTRL_EN): shift dc ? 8'h40 : 8'h00, then ACK.
- DATA:
  - At the Q0 of the first bit, if byte_valid=1: load byte_in, pulse byte_ready, store byte_last.
  - If byte_valid=0: hold SCL low with SDA unchanged and the quarter counter frozen, until byte_valid is seen.
  - The byte is shifted, then ACK.
- ACK:
  - sda_in=1 at the sample point: set the abort flag, go to STOP.
  - Else, if the last byte has been sent: go to STOP.
  - Else: go to CTRL or DATA as appropriate.
- STOP:
  - Q0: SDA low, SCL low.
  - Q2: SCL released.
  - Q3: SDA released.
  - End of Q3: done=1 (and nack_err=1 if aborted), busy=0, go to IDLE.

Boundary conditions:
- start while busy: ignored.
- byte_valid while not in DATA load: ignored; byte_ready never fires outside DATA.
- The first payload byte is requested only after the address ACK (and the control ACK, when CTRL_EN=1) passes.
- NACK on the address aborts before any byte_ready.
- CLK_DIV=1 must work: quarter = 1 clock.

Decomposition:
- Package i2c_pkg holds:
  - state enum: IDLE, START, ADDR, CTRL, DATA, ACK, STOP;
  - constants CTRL_CMD=8'h00, CTRL_DATA=8'h40;
  - BITS_PER_BYTE=9.
- One sub-module, i2c_quarter_tick: a CLK_DIV counter with enable, freeze and restart, emitting a one-cycle tick and a 2-bit quarter index.

Test Plan:
- Reset mid-ADDR:
  - Stimulus: assert reset for 1 cycle.
  - Required: next cycle scl_oe=0, sda_oe=0, busy=0; no done pulse.
- Command burst:
  - Stimulus: CLK_DIV=2, CTRL_EN=1, dc=0, addr_sel=0; stream 8'hAE, then 8'hAF with byte_last=1; slave model ACKs all bytes.
  - Required: bus carries 0x78, 0x00, 0xAE, 0xAF; exactly 2 byte_ready pulses; done 8+4*72+8 clocks after start; nack_err=0.
- Data mode with alternate address:
  - Stimulus: dc=1, addr_sel=1, addr_in=7'h3D; one byte 8'h55 with byte_last=1.
  - Required: bus carries 0x7A, 0x40, 0x55; then STOP.
- Address NACK:
  - Stimulus: slave leaves SDA high on the address ACK bit.
  - Required: STOP follows immediately; done and nack_err pulse together; zero byte_ready pulses.
- Stall:
  - Stimulus: drop byte_valid for 50 clocks before the second payload byte.
  - Required: scl_oe held at 1 for the whole gap; transfer resumes with correct bit timing; no glitch on SDA while SCL is high.
- Start while busy:
  - Stimulus: pulse start mid-transaction.
  - Required: pulse ignored; exactly one done per accepted start.
